fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameters SHALL be: PC_SIZE, 32, PC width; INSTR_SIZE, 32, instruction width; RESET_PC, 0, first fetch address.
REQ-002 One clock; reset is synchronous and active-low. Ports SHALL be, in order:
  clk_i  in  1  clock, all state on rising edge
  rst_ni  in  1  synchronous active-low reset
  start_i  in  1  leave IDLE and begin fetching
  pc0_o  out  PC_SIZE  slot-0 fetch address to instruction_reader
  pc1_o  out  PC_SIZE  slot-1 fetch address, always pc0_o+4
  instr0_i  in  INSTR_SIZE  instruction at pc0_o, combinational from reader
  instr1_i  in  INSTR_SIZE  instruction at pc1_o
  done_i  in  1  reader end-of-instructions flag for current pc0_o
  redirect_i  in  1  branch/jump redirect request
  redirect_pc_i  in  PC_SIZE  redirect target
  valid_o  out  1  fetch packet valid toward decode
  ready_i  in  1  decode accepts packet
  pkt_pc_o  out  PC_SIZE  slot-0 address of held packet
  instr0_o  out  INSTR_SIZE  held slot-0 instruction
  instr1_o  out  INSTR_SIZE  held slot-1 instruction
  slot_vld_o  out  2  per-slot valid, bit0 = slot 0
  halted_o  out  1  end of program reached and drained

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DONE; encoding lives in the package.
REQ-004 IDLE->FETCH on start_i; FETCH->DONE on advance with done_i=1; any state->FETCH on redirect_i (IDLE only after start_i has been seen).
REQ-005 pc0_o SHALL be the fetch PC register, combinationally; pc1_o = pc0_o + 4, modulo 2^PC_SIZE.
REQ-006 Advance SHALL occur in FETCH when done_i=0 and (valid_o=0 or ready_i=1); on advance, the packet register loads {pc0_o, instr0_i, instr1_i}, valid_o<=1, slot_vld_o<=2'b11, and PC <= PC+8 (wraps at 2^PC_SIZE).
REQ-007 Packet transfer SHALL occur on valid_o & ready_i; without same-cycle advance, valid_o<=0 next cycle; packet fields SHALL hold stable while valid_o=1 and ready_i=0.
REQ-008 In FETCH with done_i=1, no packet is loaded, PC holds, FSM goes to DONE; the held packet still drains normally.
REQ-009 halted_o SHALL be 1 exactly when state=DONE and valid_o=0.
REQ-010 redirect_i SHALL have priority over advance, transfer and done_i: next cycle valid_o=0, slot_vld_o=0, PC <= aligned target, state=FETCH; the in-flight packet is dropped even if ready_i=1 that cycle.
REQ-011 Fetch is 1-cycle latency: a packet appears the cycle after its PC is presented; back-to-back throughput is 2 instructions/cycle while ready_i=1.

Reset
REQ-012 With rst_ni=0 at a clock edge: state=IDLE, PC=RESET_PC, valid_o=0, slot_vld_o=0, pkt_pc_o=0, instr0_o=instr1_o=0, halted_o=0; reset mid-packet discards it.

Configuration
REQ-013 Macro FETCH_MISALIGN_EN: when defined, a redirect target with bit2=1 SHALL set PC to target-4 and mark the first subsequent packet slot_vld_o=2'b10; when undefined, bit2 (and bits 1:0 always) of the target SHALL be cleared and all packets carry 2'b11.

Structure
REQ-014 Package fetch_pkg SHALL hold the FSM state enum, FETCH_STRIDE=8, and SLOT_COUNT=2.
REQ-015 One sub-module, fetch_pkt_reg (packet register with valid/ready hold), is natural; the FSM and PC live in fetch_controller.

Verification
REQ-016 Reset then start_i, ready_i=1: pc0_o 0,8,16,... each cycle; first valid_o the cycle after start; pkt_pc_o trails pc0_o by 8.
REQ-017 ready_i=0 for 3 cycles at pkt_pc_o=0x10: packet stable, pc0_o holds 0x18; ready_i=1 resumes 0x18, 0x20 with no loss or duplicate.
REQ-018 done_i=1 at pc0_o=0x40 with packet 0x38 held and ready_i=0: state DONE, halted_o=0 until ready_i=1, then halted_o=1.
REQ-019 redirect_i with target 0x100 while valid_o=1, ready_i=1: packet dropped, next pc0_o=0x100, next packet pkt_pc_o=0x100; also from DONE, halted_o clears.
REQ-020 Redirect to 0x104: with FETCH_MISALIGN_EN pkt_pc_o=0x100, slot_vld_o=2'b10; without, pkt_pc_o=0x100, slot_vld_o=2'b11.
REQ-021 rst_ni=0 mid-stream with valid_o=1: next cycle all outputs at reset values, pc0_o=RESET_PC, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-slot instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_e;

    localparam int FETCH_STRIDE = 8;
    localparam int SLOT_COUNT   = 2;

    localparam logic [SLOT_COUNT-1:0] SLOTS_ALL  = 2'b11;
    localparam logic [SLOT_COUNT-1:0] SLOTS_HIGH = 2'b10;

endpackage

// File: rtl/fetch_pkt_reg.sv
// Fetch packet holding register: loads a new packet, holds it while decode
// stalls, and drops valid on transfer or flush.
module fetch_pkt_reg
    import fetch_pkg::*;
#(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  load_i,
    input  logic                  ready_i,
    input  logic [PC_SIZE-1:0]    pc_i,
    input  logic [INSTR_SIZE-1:0] instr0_i,
    input  logic [INSTR_SIZE-1:0] instr1_i,
    input  logic [SLOT_COUNT-1:0] slot_vld_i,
    output logic                  valid_o,
    output logic [PC_SIZE-1:0]    pkt_pc_o,
    output logic [INSTR_SIZE-1:0] instr0_o,
    output logic [INSTR_SIZE-1:0] instr1_o,
    output logic [SLOT_COUNT-1:0] slot_vld_o
);

    logic                  vld_p1;
    logic [PC_SIZE-1:0]    pc_p1;
    logic [INSTR_SIZE-1:0] instr0_p1;
    logic [INSTR_SIZE-1:0] instr1_p1;
    logic [SLOT_COUNT-1:0] slot_p1;

    // Stage p1: packet register; flush beats load, load beats plain transfer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            instr0_p1 <= '0;
            instr1_p1 <= '0;
            slot_p1   <= '0;
        end else if (flush_i) begin
            vld_p1  <= 1'b0;
            slot_p1 <= '0;
        end else if (load_i) begin
            vld_p1    <= 1'b1;
            pc_p1     <= pc_i;
            instr0_p1 <= instr0_i;
            instr1_p1 <= instr1_i;
            slot_p1   <= slot_vld_i;
        end else if (vld_p1 && ready_i) begin
            vld_p1  <= 1'b0;
            slot_p1 <= '0;
        end
    end

    assign valid_o    = vld_p1;
    assign pkt_pc_o   = pc_p1;
    assign instr0_o   = instr0_p1;
    assign instr1_o   = instr1_p1;
    assign slot_vld_o = slot_p1;

endmodule

// File: rtl/fetch_controller.sv
// Dual-slot fetch controller: FSM, fetch PC and redirect handling.
// Optional FETCH_MISALIGN_EN marks slot 0 invalid after a redirect into the upper word.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                  PC_SIZE    = 32,
    parameter int                  INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic [PC_SIZE-1:0]    pc0_o,
    output logic [PC_SIZE-1:0]    pc1_o,
    input  logic [INSTR_SIZE-1:0] instr0_i,
    input  logic [INSTR_SIZE-1:0] instr1_i,
    input  logic                  done_i,
    input  logic                  redirect_i,
    input  logic [PC_SIZE-1:0]    redirect_pc_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [PC_SIZE-1:0]    pkt_pc_o,
    output logic [INSTR_SIZE-1:0] instr0_o,
    output logic [INSTR_SIZE-1:0] instr1_o,
    output logic [1:0]            slot_vld_o,
    output logic                  halted_o
);

    fetch_state_e          state_q, state_d;
    logic [PC_SIZE-1:0]    pc_q;
    logic                  redir;
    logic                  active;
    logic                  advance;
    logic [SLOT_COUNT-1:0] slot_vld_d;
    logic [PC_SIZE-1:0]    redir_target;

    // A redirect in IDLE only counts once start_i is seen alongside it.
    assign redir        = redirect_i && ((state_q != ST_IDLE) || start_i);
    assign active       = (state_q == ST_FETCH) || ((state_q == ST_IDLE) && start_i);
    assign advance      = active && !done_i && (!valid_o || ready_i) && !redir;
    assign redir_target = redirect_pc_i & ~PC_SIZE'(7);

    always_comb begin
        state_d = state_q;
        if (redir) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_i) state_d = done_i ? ST_DONE : ST_FETCH;
                ST_FETCH: if (done_i)  state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    // Stage p0: fetch PC and FSM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (redir)
                pc_q <= redir_target;
            else if (advance)
                pc_q <= pc_q + PC_SIZE'(FETCH_STRIDE);
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic skip_lo_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            skip_lo_q <= 1'b0;
        else if (redir)
            skip_lo_q <= redirect_pc_i[2];
        else if (advance)
            skip_lo_q <= 1'b0;
    end

    assign slot_vld_d = skip_lo_q ? SLOTS_HIGH : SLOTS_ALL;
`else
    assign slot_vld_d = SLOTS_ALL;
`endif

    fetch_pkt_reg #(
        .PC_SIZE    (PC_SIZE),
        .INSTR_SIZE (INSTR_SIZE)
    ) u_pkt_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (redir),
        .load_i     (advance),
        .ready_i    (ready_i),
        .pc_i       (pc_q),
        .instr0_i   (instr0_i),
        .instr1_i   (instr1_i),
        .slot_vld_i (slot_vld_d),
        .valid_o    (valid_o),
        .pkt_pc_o   (pkt_pc_o),
        .instr0_o   (instr0_o),
        .instr1_o   (instr1_o),
        .slot_vld_o (slot_vld_o)
    );

    assign pc0_o    = pc_q;
    assign pc1_o    = pc_q + PC_SIZE'(4);
    assign halted_o = (state_q == ST_DONE) && !valid_o;

endmodule
